// File: rtl/bit_slice_serializer_pkg.sv
// Shared definitions for the bit-slice serializer: FSM encodings, default sizes
// and the counter-width helper. These encodings and defaults must match series_adder.
package bit_slice_serializer_pkg;

    localparam logic ST_LOAD   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    localparam int unsigned DEF_M = 8;
    localparam int unsigned DEF_N = 8;

    // One extra bit so a counter can reach its limit without aliasing to zero.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/word_shift_bank.sv
// M slots of N bits each, with one write port and a common right shift.
// Only the slot LSBs are visible; all control lives in the parent.
module word_shift_bank #(
    parameter int unsigned M    = 8,
    parameter int unsigned N    = 8,
    parameter int unsigned IdxW = $clog2(M)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_wr_en,
    input  logic [IdxW-1:0] i_wr_idx,
    input  logic [N-1:0]    i_wr_data,
    input  logic            i_shift_en,
    output logic [M-1:0]    o_lsbs
);

    logic [N-1:0] r_slot [M];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < M; k++) r_slot[k] <= '0;
        end else if (i_clr) begin
            for (int unsigned k = 0; k < M; k++) r_slot[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < M; k++) begin
                if (i_wr_en && (i_wr_idx == IdxW'(k))) begin
                    r_slot[k] <= i_wr_data;
                end else if (i_shift_en) begin
                    r_slot[k] <= r_slot[k] >> 1;
                end
            end
        end
    end

    always_comb begin
        o_lsbs = '0;
        for (int unsigned k = 0; k < M; k++) o_lsbs[k] = r_slot[k][0];
    end

endmodule

// File: rtl/bit_slice_serializer.sv
// Buffers M N-bit words, then streams N bit-slices LSB first (lane k = word k)
// straight into the serial adder's data/data_vld inputs.
module bit_slice_serializer
    import bit_slice_serializer_pkg::*;
#(
    parameter int unsigned M = DEF_M,
    parameter int unsigned N = DEF_N
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_s_vld,
    output logic         o_s_rdy,
    input  logic [N-1:0] i_s_data,
    output logic [M-1:0] o_data,
    output logic         o_data_vld,
    output logic         o_busy
);

    localparam int unsigned WCW  = cnt_width(M);
    localparam int unsigned BCW  = cnt_width(N);
    localparam int unsigned IdxW = $clog2(M);

    localparam logic [WCW-1:0] WORD_LAST = WCW'(M - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(N - 1);

    logic           r_state;
    logic [WCW-1:0] r_word_cnt;
    logic [BCW-1:0] r_bit_cnt;

    logic           w_state_nxt;
    logic [WCW-1:0] w_word_cnt_nxt;
    logic [BCW-1:0] w_bit_cnt_nxt;
    logic           w_accept;
    logic           w_shift;
    logic [M-1:0]   w_lsbs;

    // Clear blocks both the write and the shift so the bank is only zeroed.
    assign w_accept = (r_state == ST_LOAD) && i_s_vld && !i_clear;
    assign w_shift  = (r_state == ST_STREAM) && !i_clear;

    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        if (i_clear) begin
            w_state_nxt    = ST_LOAD;
            w_word_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
        end else if (r_state == ST_LOAD) begin
            if (w_accept) begin
                if (r_word_cnt == WORD_LAST) begin
                    w_state_nxt    = ST_STREAM;
                    w_word_cnt_nxt = '0;
                end else begin
                    w_word_cnt_nxt = r_word_cnt + 1'b1;
                end
            end
        end else begin
            if (r_bit_cnt == BIT_LAST) begin
                w_state_nxt   = ST_LOAD;
                w_bit_cnt_nxt = '0;
            end else begin
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_LOAD;
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
        end
    end

    word_shift_bank #(
        .M    (M),
        .N    (N),
        .IdxW (IdxW)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_clear),
        .i_wr_en    (w_accept),
        .i_wr_idx   (r_word_cnt[IdxW-1:0]),
        .i_wr_data  (i_s_data),
        .i_shift_en (w_shift),
        .o_lsbs     (w_lsbs)
    );

    assign o_s_rdy    = (r_state == ST_LOAD);
    assign o_data_vld = (r_state == ST_STREAM);
    assign o_busy     = o_data_vld;
    // Gated by registered state only, so adder inputs stay quiet outside a stream.
    assign o_data     = w_lsbs & {M{o_data_vld}};

endmodule
